freq_div_prog: RTL and testbench
================================

// Module: freq_div_prog
// PURPOSE
//   Multi-channel programmable clock divider. Each channel divides clk by a
//   runtime divisor D (2..2^DIV_W-1, even or odd). It produces a near-50%-duty
//   divided clock and a one-cycle tick at the start of each period.
//   Divisor updates are glitch-free and take effect only at a period boundary.
//   A common sync input phase-aligns all channels.
// PARAMETERS
//   NUM_CH   4   number of independent divider channels
//   DIV_W    8   divisor/counter width; max divisor 2^DIV_W-1
//   DEF_DIV  2   divisor loaded into every channel at reset (must be >=2)
//   CH_W     localparam = $clog2(NUM_CH>1 ? NUM_CH : 2)
// PORTS
//   clk        in   1        single clock
//   rst        in   1        synchronous reset, active-high
//   ch_en      in   NUM_CH   per-channel enable
//   sync       in   1        restart all channels' period, one-cycle pulse
//   cfg_valid  in   1        divisor update request
//   cfg_ready  out  1        update accepted when cfg_valid & cfg_ready
//   cfg_ch     in   CH_W     target channel
//   cfg_div    in   DIV_W    new divisor
//   cfg_err    out  1        one-cycle pulse: accepted request was illegal
//   div_out    out  NUM_CH   divided clocks (registered)
//   tick       out  NUM_CH   one-cycle pulse, first cycle of each period
// BEHAVIOUR
// - Reset: cnt=0, active div=DEF_DIV, no pending update, div_out=0, tick=0,
//   cfg_err=0 for all channels.
// - Per channel: cnt counts 0..D-1 and wraps to 0. HI = ceil(D/2).
// - div_out and tick are registered from the current cnt:
//   - div_out <= (cnt < HI)
//   - tick <= (cnt == 0)
//   - This gives exactly HI cycles high and D-HI cycles low.
//   - tick coincides with the first high cycle of div_out.
//   - Example, D=4, first cycles after rst falls: div_out 1,1,0,0,1,1..;
//     tick 1,0,0,0,1,0..
// - ch_en[i]=0:
//   - cnt held 0; div_out and tick forced 0 on the next edge.
//   - On re-enable the channel restarts exactly as after reset, with the
//     current active divisor.
// - Config handshake:
//   - cfg_ready = ~pend_v[cfg_ch] (combinational). One pending update per
//     channel.
//   - If cfg_ch >= NUM_CH, cfg_ready=1 so the request is never stalled.
//   - On accept with cfg_div>=2 and cfg_ch<NUM_CH: pend_div<=cfg_div, pend_v<=1.
//   - On accept with cfg_div<2 or cfg_ch>=NUM_CH: discarded; cfg_err=1 on the
//     next cycle.
//   - The pending divisor becomes active on the edge where cnt wraps
//     (cnt==D_old-1). The new period starts with the new D; pend_v clears on
//     the same edge.
//   - If the channel is disabled, or sync is high, the pending divisor is
//     applied on that edge instead.
//   - No partial periods or glitches on div_out from a divisor change.
//   - Accept and apply in the same cycle on the same channel: the apply wins,
//     the new write is stored as pending, and pend_v stays 1.
// - sync=1 at an edge:
//   - Every enabled channel: cnt<=0, div_out<=0, tick<=0, pending divisor
//     applied.
//   - The next edge starts a fresh high phase, so all channels rise together.
//   - sync with rst: rst wins.
// - rst asserted mid-operation returns all state to reset values on the next
//   edge. Any pending update is lost.
// - Counter arithmetic is DIV_W bits unsigned and never exceeds D-1.
// TESTING
// - Reset, all ch_en=1, DEF_DIV=2 -> every div_out toggles 1,0,1,0; tick 1,0,1,0.
// - ch0 cfg_div=5 -> after current period ends: div_out 1,1,1,0,0 repeating;
//   tick every 5th cycle.
// - ch1 D=4 running, cfg_div=6 accepted at cnt=1 -> current period completes
//   (4 cycles); then 1,1,1,0,0,0; cfg_ready[ch1] low until applied.
// - Second cfg to same channel while pending -> cfg_ready=0; accepted one
//   cycle after apply.
// - cfg_div=0, cfg_div=1, or cfg_ch=NUM_CH -> cfg_err pulses once; all
//   channels unchanged.
// - ch0 D=3, ch2 D=7, sync pulse -> both low one cycle, then rise together
//   with tick.
// - rst mid-period and ch_en drop -> outputs 0 next edge; restart matches the
//   post-reset sequence.

Source files
------------

// File: rtl/freq_div_prog.sv
// freq_div_prog: multi-channel programmable clock divider.
// Each channel divides clk by a runtime divisor D (2..2^DIV_W-1) and produces
// a near-50% duty clock (ceil(D/2) cycles high) plus a one-cycle tick on the
// first high cycle of every period. Divisor writes go through a valid/ready
// handshake into a one-deep pending slot per channel. The pending value is
// applied only at a period boundary, on sync, or while the channel is
// disabled, so div_out never shows a partial period.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ch_en         per-channel enable (disabled: held at count 0, outputs low)
//   sync          restarts the period of every enabled channel
//   cfg_valid/cfg_ready/cfg_ch/cfg_div   divisor update handshake
//   cfg_err       one-cycle pulse after an accepted illegal request
//   div_out, tick registered divided clocks and period-start pulses
module freq_div_prog #(
   parameter  int NUM_CH  = 4,
   parameter  int DIV_W   = 8,
   parameter  int DEF_DIV = 2,
   localparam int CH_W    = $clog2(NUM_CH > 1 ? NUM_CH : 2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] div_out,
   output logic [NUM_CH-1:0] tick
);

   // pend_v padded to the full cfg_ch range so an out-of-range channel
   // number never indexes past the vector
   localparam int NPAD = 2 ** CH_W;

   logic [NUM_CH-1:0] pend_v;
   logic [NPAD-1:0]   pend_pad;
   logic              ch_ok;
   logic              div_ok;
   logic              accept;

   assign ch_ok     = int'(cfg_ch) < NUM_CH;
   assign div_ok    = cfg_div >= DIV_W'(2);
   assign pend_pad  = NPAD'(pend_v);
   assign cfg_ready = ~ch_ok | ~pend_pad[cfg_ch];
   assign accept    = cfg_valid & cfg_ready;

   always_ff @(posedge clk) begin
      if (rst) cfg_err <= 1'b0;
      else     cfg_err <= accept & ~(ch_ok & div_ok);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] div_act;
      logic [DIV_W-1:0] pend_div;
      logic [DIV_W:0]   hi;
      logic             pv;
      logic             dout_q;
      logic             tick_q;
      logic             wrap;
      logic             apply;
      logic             wr;

      // one extra bit so ceil(D/2) cannot overflow at the maximum divisor
      assign hi    = ({1'b0, div_act} + (DIV_W+1)'(1)) >> 1;
      assign wrap  = cnt == div_act - DIV_W'(1);
      assign apply = pv & (~ch_en[g] | sync | wrap);
      assign wr    = accept & ch_ok & div_ok & (cfg_ch == CH_W'(g));

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt      <= '0;
            div_act  <= DIV_W'(DEF_DIV);
            pend_div <= '0;
            pv       <= 1'b0;
            dout_q   <= 1'b0;
            tick_q   <= 1'b0;
         end else begin
            if (~ch_en[g] | sync) begin
               cnt    <= '0;
               dout_q <= 1'b0;
               tick_q <= 1'b0;
            end else begin
               dout_q <= {1'b0, cnt} < hi;
               tick_q <= cnt == '0;
               cnt    <= wrap ? '0 : cnt + DIV_W'(1);
            end
            if (apply) begin
               div_act <= pend_div;
               pv      <= 1'b0;
            end
            // a write landing on the apply edge becomes the next pending value
            if (wr) begin
               pend_div <= cfg_div;
               pv       <= 1'b1;
            end
         end
      end

      assign pend_v[g]  = pv;
      assign div_out[g] = dout_q;
      assign tick[g]    = tick_q;
   end

endmodule

// File: tb/tb_freq_div_prog.sv
// Bench for freq_div_prog with three channels, so cfg_ch=3 is an illegal
// channel. A cycle model predicts outputs; predictions are queued before each
// edge and compared after it. Directed pattern checks cover the key examples.
module tb_freq_div_prog;
   localparam int NCH = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] ch_en;
   logic           sync;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [1:0]     cfg_ch;
   logic [7:0]     cfg_div;
   logic           cfg_err;
   logic [NCH-1:0] div_out;
   logic [NCH-1:0] tick;

   freq_div_prog #(.NUM_CH(NCH), .DIV_W(8), .DEF_DIV(2)) dut (
      .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_err(cfg_err), .div_out(div_out), .tick(tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCH-1:0] dout;
      logic [NCH-1:0] tk;
      logic           err;
   } exp_t;

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_err = 0;

   int   m_cnt[NCH];
   int   m_d[NCH];
   int   m_pd[NCH];
   bit   m_pv[NCH];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock: predict, queue, wait for the edge, compare
   task automatic cycle();
      exp_t e;
      logic exp_rdy;
      bit   acc, legal, ap;
      #1;
      exp_rdy = (cfg_ch >= 2'(NCH)) ? 1'b1 : !m_pv[cfg_ch];
      if (!rst) chk("cfg_ready", cfg_ready, exp_rdy);
      acc   = cfg_valid && exp_rdy;
      legal = (cfg_ch < 2'(NCH)) && (cfg_div >= 8'd2);
      for (int i = 0; i < NCH; i++) begin
         if (rst) begin
            m_cnt[i] = 0; m_d[i] = 2; m_pv[i] = 0;
            e.dout[i] = 1'b0; e.tk[i] = 1'b0;
         end else begin
            ap = m_pv[i] && (!ch_en[i] || sync || m_cnt[i] == m_d[i] - 1);
            if (!ch_en[i] || sync) begin
               e.dout[i] = 1'b0; e.tk[i] = 1'b0; m_cnt[i] = 0;
            end else begin
               e.dout[i] = m_cnt[i] < (m_d[i] + 1) / 2;
               e.tk[i]   = m_cnt[i] == 0;
               m_cnt[i]  = (m_cnt[i] == m_d[i] - 1) ? 0 : m_cnt[i] + 1;
            end
            if (ap) begin m_d[i] = m_pd[i]; m_pv[i] = 0; end
            if (acc && legal && int'(cfg_ch) == i) begin
               m_pd[i] = int'(cfg_div); m_pv[i] = 1;
            end
         end
      end
      e.err = !rst && acc && !legal;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("div_out", div_out, e.dout);
      chk("tick", tick, e.tk);
      chk("cfg_err", cfg_err, e.err);
   endtask

   task automatic cfg_pulse(input int ch, input int d);
      cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(d);
      cycle();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_tick(input int ch, input int d);
      int n = 0;
      while (!(tick[ch] === 1'b1 && m_d[ch] == d) && n < 40) begin
         cycle();
         n++;
      end
      chk("wait_tick", n < 40, 1);
   endtask

   // records div_out/tick of one channel starting with the current cycle
   task automatic cap(input int ch, input int n, output logic [15:0] bo, output logic [15:0] bt);
      bo = 16'(div_out[ch]);
      bt = 16'(tick[ch]);
      for (int k = 1; k < n; k++) begin
         cycle();
         bo = {bo[14:0], div_out[ch]};
         bt = {bt[14:0], tick[ch]};
      end
   endtask

   initial begin
      logic [15:0] bo, bt;
      int n, k;
      rst = 1'b1; ch_en = '1; sync = 1'b0;
      cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = 0; m_d[i] = 2; m_pd[i] = 0; m_pv[i] = 0;
      end

      cycle(); cycle();
      chk("rst_dout", div_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_err", cfg_err, 0);

      rst = 1'b0;
      cycle();
      cap(0, 4, bo, bt);
      chk("d2_out", bo[3:0], 4'b1010);
      chk("d2_tick", bt[3:0], 4'b1010);

      cfg_pulse(0, 5);
      wait_tick(0, 5);
      cap(0, 5, bo, bt);
      chk("d5_out", bo[4:0], 5'b11100);
      chk("d5_tick", bt[4:0], 5'b10000);

      // ch1: D=4, then 6 written at cnt=1, then 3 queued behind it
      cfg_pulse(1, 4);
      wait_tick(1, 4);
      cfg_pulse(1, 6);
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
      #1;
      chk("rdy_pend", cfg_ready, 0);
      n = 0;
      while (!cfg_ready && n < 20) begin
         cycle();
         n++;
      end
      chk("rdy_wait", n, 2);
      cycle();
      cfg_valid = 1'b0;
      wait_tick(1, 6);
      cap(1, 6, bo, bt);
      chk("d6_out", bo[5:0], 6'b111000);
      chk("d6_tick", bt[5:0], 6'b100000);
      wait_tick(1, 3);
      cap(1, 3, bo, bt);
      chk("d3_out", bo[2:0], 3'b110);
      chk("d3_tick", bt[2:0], 3'b100);

      // illegal requests: divisor 0, divisor 1, nonexistent channel
      cfg_pulse(0, 0);
      chk("err_div0", cfg_err, 1);
      cycle();
      chk("err_once0", cfg_err, 0);
      cfg_pulse(2, 1);
      chk("err_div1", cfg_err, 1);
      cycle();
      chk("err_once1", cfg_err, 0);
      cfg_pulse(3, 5);
      chk("err_ch", cfg_err, 1);
      cycle();
      chk("err_once2", cfg_err, 0);

      // sync aligns ch0 (D=3) and ch2 (D=7)
      cfg_pulse(0, 3);
      cfg_pulse(2, 7);
      wait_tick(0, 3);
      wait_tick(2, 7);
      cycle(); cycle();
      sync = 1'b1;
      cycle();
      sync = 1'b0;
      chk("sync_low", {div_out[2], div_out[0]}, 2'b00);
      cycle();
      chk("sync_rise", {div_out[2], div_out[0], tick[2], tick[0]}, 4'hF);

      // reset mid-period returns to DEF_DIV behaviour
      cycle(); cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_mid", div_out, 0);
      cycle();
      cap(0, 4, bo, bt);
      chk("rst_re_out", bo[3:0], 4'b1010);

      // pending divisor applied while disabled; restart like after reset
      cfg_pulse(2, 4);
      ch_en = 3'b011;
      cycle();
      chk("dis_out", div_out[2], 0);
      cycle();
      ch_en = 3'b111;
      cycle();
      cap(2, 4, bo, bt);
      chk("reen_out", bo[3:0], 4'b1100);
      chk("reen_tick", bt[3:0], 4'b1000);

      // random mix of updates, syncs, enables and resets
      for (int c = 0; c < 400; c++) begin
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_div   = 8'($urandom_range(0, 12));
         sync      = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 9) == 0) begin
            k = $urandom_range(0, NCH - 1);
            ch_en[k] = ~ch_en[k];
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
